// File: rtl/uart_rx_os8.sv
// UART receiver driven by an 8x oversampling tick, with a one-entry valid/ready output buffer.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os8 #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 bclkx8,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state, state_n;
  logic [2:0]           os_cnt, os_n;
  logic [BCW-1:0]       bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic [2:0]           bclk_sync;
  logic                 rxs;
  logic                 tick;
  logic                 frame_done;
  logic                 stop_bad;
  logic                 stop_sample;

  // Both synchronisers; rxd stages come out of reset at the idle-high line level.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_sync   <= '1;
      bclk_sync <= '0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rx_sync   <= {rx_sync[SYNC_STAGES-2:0], rxd};
      bclk_sync <= {bclk_sync[1:0], bclkx8};
    end
  end

  assign rxs  = rx_sync[SYNC_STAGES-1];
  assign tick = bclk_sync[1] & ~bclk_sync[2];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      bit_cnt <= bit_n;
    end
  end

  // NOTE: the shift register is plain datapath with no reset; it is only observed after a full frame.
  always_ff @(posedge sys_clk) begin
    shift_q <= shift_n;
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_n;

  always_ff @(posedge sys_clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_n;
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_n     = state;
    os_n        = os_cnt;
    bit_n       = bit_cnt;
    shift_n     = shift_q;
    frame_done  = 1'b0;
    stop_bad    = 1'b0;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n       = par_q;
`endif
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            os_n    = 3'd0;
          end
        end
        START: begin
          os_n = os_cnt + 3'd1;
          // Third tick after detection lands mid start bit; a high line here was a glitch.
          if (os_cnt == 3'd2) begin
            if (rxs) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              os_n    = 3'd0;
              bit_n   = '0;
            end
          end
        end
        DATA: begin
          os_n = os_cnt + 3'd1;
          if (os_cnt == 3'd7) begin
            shift_n = {rxs, shift_q[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          os_n = os_cnt + 3'd1;
          if (os_cnt == 3'd7) begin
            par_n   = rxs;
            state_n = STOP;
          end
        end
`endif
        STOP: begin
          os_n = os_cnt + 3'd1;
          if (os_cnt == 3'd7) begin
            stop_sample = 1'b1;
            if (rxs) begin
              frame_done = 1'b1;
              state_n    = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_n  = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low break must return high before another start bit is accepted.
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output buffer: load when empty or being drained this cycle, otherwise drop and flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= stop_bad;
      overrun     <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= stop_sample & (^{shift_q, par_q});
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os8.sv
// Scoreboard bench for uart_rx_os8: frames are driven at the 8x-tick rate, expected bytes queued,
// and a monitor pops and compares on every rx_valid&rx_ready handshake.
module tb_uart_rx_os8;

  localparam int DATA_BITS = 8;

  logic                 sys_clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 bclkx8 = 1'b0;
  logic                 rxd = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 framing_err;
  logic                 overrun;
  logic                 parity_err;

  uart_rx_os8 #(.DATA_BITS(DATA_BITS), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .bclkx8      (bclkx8),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5  sys_clk = ~sys_clk;
  always #40 bclkx8  = ~bclkx8;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int seen_fe = 0, seen_ov = 0, seen_pe = 0;
  int valid_cycles = 0;
  logic [DATA_BITS-1:0] exp_q[$];
  bit ready_force = 1'b1;
  bit rand_ready  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Consumer: either a fixed ready level or a random 75%-ready pattern.
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      rx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: pulse widths, data stability, handshake scoreboard.
  initial begin
    logic prev_valid, prev_hs, prev_fe, prev_ov, prev_pe;
    logic [DATA_BITS-1:0] prev_data, want;
    prev_valid = 0; prev_hs = 0; prev_fe = 0; prev_ov = 0; prev_pe = 0; prev_data = '0;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        prev_valid = 0; prev_hs = 0; prev_fe = 0; prev_ov = 0; prev_pe = 0;
      end else begin
        if (rx_valid) valid_cycles++;
        if (framing_err) begin seen_fe++; check("framing_err width", 32'(prev_fe), 0); end
        if (overrun)     begin seen_ov++; check("overrun width", 32'(prev_ov), 0); end
        if (parity_err)  begin seen_pe++; check("parity_err width", 32'(prev_pe), 0); end
        if (prev_valid && !prev_hs && rx_valid)
          check("rx_data stable", 32'(rx_data), 32'(prev_data));
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h, no byte expected (t=%0t)", rx_data, $time);
          end else begin
            want = exp_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(want));
          end
        end
        prev_valid = rx_valid;
        prev_hs    = rx_valid & rx_ready;
        prev_data  = rx_data;
        prev_fe    = framing_err;
        prev_ov    = overrun;
        prev_pe    = parity_err;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bit cell = 8 bclkx8 periods, changing on the bclkx8 falling edge.
  task automatic drive_bit(input logic b);
    @(negedge bclkx8);
    rxd = b;
    repeat (7) @(negedge bclkx8);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
  endtask

  // Reference outcome of one frame from the line-level rules.
  task automatic expect_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input bit buf_free);
    if (stop_b) begin
      if (buf_free) exp_q.push_back(d);
      else          exp_ov++;
    end else begin
      exp_fe++;
    end
`ifdef UART_RX_PARITY_EN
    if ((^d) != par_b) exp_pe++;
`endif
  endtask

  task automatic check_counts(input string tag);
    check({tag, " framing_err count"}, 32'(seen_fe), 32'(exp_fe));
    check({tag, " overrun count"},     32'(seen_ov), 32'(exp_ov));
    check({tag, " parity_err count"},  32'(seen_pe), 32'(exp_pe));
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || rx_valid) && k < 4000) begin
      @(negedge sys_clk);
      k++;
    end
    check({tag, " pending bytes"}, 32'(exp_q.size()), 0);
    check({tag, " rx_valid drained"}, 32'(rx_valid), 0);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, " rx_valid"},    32'(rx_valid), 0);
    check({tag, " rx_data"},     32'(rx_data), 0);
    check({tag, " framing_err"}, 32'(framing_err), 0);
    check({tag, " overrun"},     32'(overrun), 0);
    check({tag, " parity_err"},  32'(parity_err), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       sb, pb;

    repeat (4) @(negedge sys_clk);
    check_quiet_outputs("reset");
    rst = 1'b0;
    idle_bits(1);

    // Clean frame, consumer always ready: a single-cycle rx_valid.
    valid_cycles = 0;
    expect_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(1);
    wait_drain("a5");
    check("a5 rx_valid cycles", 32'(valid_cycles), 1);
    check_counts("a5");

    // Start-bit glitch two ticks long, then a real frame.
    @(negedge bclkx8); rxd = 1'b0;
    repeat (2) @(negedge bclkx8);
    rxd = 1'b1;
    repeat (16) @(negedge bclkx8);
    check("glitch rx_valid", 32'(rx_valid), 0);
    expect_frame(8'h3C, 1'b1, ^8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle_bits(1);
    wait_drain("3c");
    check_counts("glitch");

    // Stop bit low, then the line held low as a break.
    expect_frame(8'h55, 1'b0, ^8'h55, 1'b1);
    send_frame(8'h55, 1'b0, ^8'h55);
    repeat (40) @(negedge bclkx8);
    check("break rx_valid", 32'(rx_valid), 0);
    check_counts("break");
    idle_bits(2);
    expect_frame(8'h0F, 1'b1, ^8'h0F, 1'b1);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    idle_bits(1);
    wait_drain("0f");
    check_counts("after break");

    // Consumer stalled: second byte is dropped with an overrun.
    ready_force = 1'b0;
    expect_frame(8'h11, 1'b1, ^8'h11, 1'b1);
    send_frame(8'h11, 1'b1, ^8'h11);
    idle_bits(1);
    expect_frame(8'h22, 1'b1, ^8'h22, 1'b0);
    send_frame(8'h22, 1'b1, ^8'h22);
    idle_bits(1);
    check("overrun held rx_valid", 32'(rx_valid), 1);
    check("overrun held rx_data", 32'(rx_data), 32'h11);
    check_counts("overrun");
    ready_force = 1'b1;
    wait_drain("overrun");

    // Reset during data bit 4 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    @(negedge bclkx8); rxd = 1'b1;
    repeat (2) @(negedge bclkx8);
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_quiet_outputs("mid-frame reset");
    rst = 1'b0;
    idle_bits(4);
    expect_frame(8'h81, 1'b1, ^8'h81, 1'b1);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle_bits(1);
    wait_drain("81");
    check_counts("after reset");

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h07, 1'b1, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    wait_drain("parity ok");
    check_counts("parity ok");
    expect_frame(8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    wait_drain("parity bad");
    check_counts("parity bad");
`endif

    // Random frames with a randomly stalling consumer and occasional bad stop bits.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 7) != 0);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      expect_frame(d, sb, pb, 1'b1);
      send_frame(d, sb, pb);
      idle_bits(int'($urandom_range(1, 2)));
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    wait_drain("random");
    check_counts("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
